alarm_set_ctrl: RTL and testbench

Controller for the alarm-minute register path of the digital clock. It sequences the user's alarm-set flow from debounced buttons: enter edit, adjust tens, adjust ones, commit. It holds the committed alarm minutes and drives the register-load strobe. It also compares the committed alarm against the running time and times the ring period. It sits between the button debouncers and the display/buzzer logic.

---
 rtl/alarm_set_ctrl_pkg.sv | 20 ++
 rtl/tick_down_cnt.sv | 40 ++++
 rtl/alarm_set_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_alarm_set_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_set_ctrl_pkg.sv
// Shared types and constants for the alarm-minute set/ring controller.
// Holds the FSM state encoding, the BCD digit limits and a small digit-increment helper.
package alarm_set_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EDIT_TENS = 2'd1,
    EDIT_ONES = 2'd2,
    COMMIT    = 2'd3
  } state_e;

  localparam logic [3:0] TENS_MAX = 4'd5;
  localparam logic [3:0] ONES_MAX = 4'd9;

  // Wraps to zero past the digit's limit; also recovers an out-of-range digit.
  function automatic logic [3:0] bcdInc(input logic [3:0] digit, input logic [3:0] maxVal);
    return (digit >= maxVal) ? 4'd0 : digit + 4'd1;
  endfunction

endpackage

// File: rtl/tick_down_cnt.sv
// Loadable down-counter stepped by the 1 Hz tick.
// expire_o marks the tick that takes the count from one to zero.
module tick_down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clear beats load beats decrement; the count parks at zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = dec_i && !load_i && !clr_i && (count_q == W'(1));

endmodule

// File: rtl/alarm_set_ctrl.sv
// Alarm-minute controller: button-driven edit/commit flow, committed alarm register,
// alarm match against the running time and the timed ring period.
module alarm_set_ctrl
  import alarm_set_ctrl_pkg::*;
#(
  parameter int TIMEOUT  = 10,
  parameter int RING_LEN = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_stop,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_min2,
  input  logic       sec_zero,
  output logic [3:0] alarm_min1,
  output logic [3:0] alarm_min2,
  output logic [3:0] edit_min1,
  output logic [3:0] edit_min2,
  output logic       editing,
  output logic       edit_sel,
  output logic       blink,
  output logic       set_min,
  output logic       ringing
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RING_LEN + 1);
  localparam logic [TW-1:0] TIMEOUT_VAL  = TW'(TIMEOUT);
  localparam logic [RW-1:0] RING_LEN_VAL = RW'(RING_LEN);

  state_e     state_q, state_d;
  logic [3:0] alarm1_q, alarm1_d;
  logic [3:0] alarm2_q, alarm2_d;
  logic [3:0] edit1_q, edit1_d;
  logic [3:0] edit2_q, edit2_d;
  logic       blink_q, blink_d;
  logic       ringing_q, ringing_d;
  logic       setMin_q, setMin_d;
  logic       editing_q, editing_d;
  logic       editSel_q, editSel_d;

  logic anyPress;
  logic inEdit;
  logic nextInEdit;
  logic alarmMatch;
  logic idleLoad;
  logic idleExpire;
  logic ringLoad;
  logic ringClr;
  logic ringExpire;

  assign anyPress   = btn_mode | btn_inc | btn_stop;
  assign inEdit     = (state_q == EDIT_TENS) || (state_q == EDIT_ONES);
  assign nextInEdit = (state_d == EDIT_TENS) || (state_d == EDIT_ONES);
  assign alarmMatch = (state_q == IDLE) && !ringing_q && tick && sec_zero &&
                      (cur_min1 == alarm1_q) && (cur_min2 == alarm2_q);

  tick_down_cnt #(.W(TW)) uIdleCnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (1'b0),
    .load_i     (idleLoad),
    .load_val_i (TIMEOUT_VAL),
    .dec_i      (tick && inEdit),
    .expire_o   (idleExpire)
  );

  tick_down_cnt #(.W(RW)) uRingCnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (ringClr),
    .load_i     (ringLoad),
    .load_val_i (RING_LEN_VAL),
    .dec_i      (tick && ringing_q),
    .expire_o   (ringExpire)
  );

  // While ringing, any button only silences the alarm and never reaches the edit flow.
  always_comb begin
    state_d   = state_q;
    alarm1_d  = alarm1_q;
    alarm2_d  = alarm2_q;
    edit1_d   = edit1_q;
    edit2_d   = edit2_q;
    ringing_d = ringing_q;
    idleLoad  = 1'b0;
    ringLoad  = 1'b0;
    ringClr   = 1'b0;

    if (ringing_q) begin
      if (anyPress) begin
        ringing_d = 1'b0;
        ringClr   = 1'b0 | 1'b1;
      end else if (ringExpire) begin
        ringing_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (btn_mode) begin
            state_d  = EDIT_TENS;
            edit1_d  = alarm1_q;
            edit2_d  = alarm2_q;
            idleLoad = 1'b1;
          end else if (alarmMatch) begin
            ringing_d = 1'b1;
            ringLoad  = 1'b1;
          end
        end
        EDIT_TENS, EDIT_ONES: begin
          idleLoad = anyPress;
          if (btn_mode) begin
            if (state_q == EDIT_TENS) begin
              state_d = EDIT_ONES;
            end else begin
              state_d  = COMMIT;
              alarm1_d = edit1_q;
              alarm2_d = edit2_q;
            end
          end else if (btn_inc) begin
            if (state_q == EDIT_TENS) begin
              edit1_d = bcdInc(edit1_q, TENS_MAX);
            end else begin
              edit2_d = bcdInc(edit2_q, ONES_MAX);
            end
          end else if (idleExpire && !anyPress) begin
            // Abandoned session: working digits fall back to the committed alarm.
            state_d = IDLE;
            edit1_d = alarm1_q;
            edit2_d = alarm2_q;
          end
        end
        COMMIT: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Decoded outputs are computed from the next state so they land in registers.
  always_comb begin
    blink_d   = 1'b0;
    editing_d = nextInEdit;
    editSel_d = (state_d == EDIT_ONES);
    setMin_d  = (state_d == COMMIT);
    if (inEdit && nextInEdit) begin
      blink_d = tick ? ~blink_q : blink_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      alarm1_q  <= 4'd0;
      alarm2_q  <= 4'd0;
      edit1_q   <= 4'd0;
      edit2_q   <= 4'd0;
      blink_q   <= 1'b0;
      ringing_q <= 1'b0;
      setMin_q  <= 1'b0;
      editing_q <= 1'b0;
      editSel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      alarm1_q  <= alarm1_d;
      alarm2_q  <= alarm2_d;
      edit1_q   <= edit1_d;
      edit2_q   <= edit2_d;
      blink_q   <= blink_d;
      ringing_q <= ringing_d;
      setMin_q  <= setMin_d;
      editing_q <= editing_d;
      editSel_q <= editSel_d;
    end
  end

  assign alarm_min1 = alarm1_q;
  assign alarm_min2 = alarm2_q;
  assign edit_min1  = edit1_q;
  assign edit_min2  = edit2_q;
  assign editing    = editing_q;
  assign edit_sel   = editSel_q;
  assign blink      = blink_q;
  assign set_min    = setMin_q;
  assign ringing    = ringing_q;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Self-checking bench for alarm_set_ctrl: directed set/wrap/timeout/ring/reset scenarios
// followed by randomized button and time traffic, all checked against a behavioural model.
module tb_alarm_set_ctrl;

  localparam int TIMEOUT  = 10;
  localparam int RING_LEN = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_stop = 1'b0;
  logic [3:0] cur_min1 = 4'd0;
  logic [3:0] cur_min2 = 4'd0;
  logic       sec_zero = 1'b0;
  logic [3:0] alarm_min1, alarm_min2, edit_min1, edit_min2;
  logic       editing, edit_sel, blink, set_min, ringing;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0 idle, 1 tens, 2 ones, 3 commit; idle time counts up.
  int mMode = 0;
  int mA1 = 0, mA2 = 0, mE1 = 0, mE2 = 0;
  int mIdle = 0;
  int mRing = 0, mRingLeft = 0;
  int mBlink = 0;

  alarm_set_ctrl #(.TIMEOUT(TIMEOUT), .RING_LEN(RING_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .btn_stop   (btn_stop),
    .cur_min1   (cur_min1),
    .cur_min2   (cur_min2),
    .sec_zero   (sec_zero),
    .alarm_min1 (alarm_min1),
    .alarm_min2 (alarm_min2),
    .edit_min1  (edit_min1),
    .edit_min2  (edit_min2),
    .editing    (editing),
    .edit_sel   (edit_sel),
    .blink      (blink),
    .set_min    (set_min),
    .ringing    (ringing)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelStep(input bit r, input bit m, input bit i, input bit s, input bit t,
                           input bit sz, input int c1, input int c2);
    bit wasEdit;
    if (r) begin
      mMode = 0; mA1 = 0; mA2 = 0; mE1 = 0; mE2 = 0;
      mIdle = 0; mRing = 0; mRingLeft = 0; mBlink = 0;
      return;
    end
    wasEdit = (mMode == 1) || (mMode == 2);
    if (mRing != 0) begin
      if (m || i || s) begin
        mRing = 0;
      end else if (t) begin
        mRingLeft--;
        if (mRingLeft == 0) mRing = 0;
      end
    end else begin
      case (mMode)
        0: begin
          if (m) begin
            mMode = 1; mE1 = mA1; mE2 = mA2; mIdle = 0;
          end else if (t && sz && c1 == mA1 && c2 == mA2) begin
            mRing = 1; mRingLeft = RING_LEN;
          end
        end
        1, 2: begin
          if (m) begin
            mIdle = 0;
            if (mMode == 1) begin
              mMode = 2;
            end else begin
              mMode = 3; mA1 = mE1; mA2 = mE2;
            end
          end else if (i) begin
            mIdle = 0;
            if (mMode == 1) mE1 = (mE1 + 1) % 6;
            else            mE2 = (mE2 + 1) % 10;
          end else if (s) begin
            mIdle = 0;
          end else if (t) begin
            mIdle++;
            if (mIdle == TIMEOUT) mMode = 0;
          end
        end
        default: mMode = 0;
      endcase
    end
    if (wasEdit && (mMode == 1 || mMode == 2)) begin
      if (t) mBlink = 1 - mBlink;
    end else begin
      mBlink = 0;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit m, input bit i, input bit s, input bit t,
                               input bit sz, input int c1, input int c2);
    rst = r; btn_mode = m; btn_inc = i; btn_stop = s; tick = t; sec_zero = sz;
    cur_min1 = 4'(c1); cur_min2 = 4'(c2);
    modelStep(r, m, i, s, t, sz, c1, c2);
    @(posedge clk);
    #1;
    checkOutput("alarm_min1", alarm_min1, mA1);
    checkOutput("alarm_min2", alarm_min2, mA2);
    checkOutput("editing", editing, (mMode == 1 || mMode == 2) ? 1 : 0);
    checkOutput("edit_sel", edit_sel, (mMode == 2) ? 1 : 0);
    checkOutput("set_min", set_min, (mMode == 3) ? 1 : 0);
    checkOutput("blink", blink, mBlink);
    checkOutput("ringing", ringing, mRing);
    if (r) begin
      checkOutput("rst_edit_min1", edit_min1, 0);
      checkOutput("rst_edit_min2", edit_min2, 0);
    end
    if (mMode == 1 || mMode == 2) begin
      checkOutput("edit_min1", edit_min1, mE1);
      checkOutput("edit_min2", edit_min2, mE2);
    end
  endtask

  task automatic idleCycle();    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic pressMode();    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic pressInc();     applyStimulus(0, 0, 1, 0, 0, 0, 0, 0); endtask
  task automatic tickOnly();     applyStimulus(0, 0, 0, 0, 1, 0, 0, 0); endtask
  task automatic resetCycle();   applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); endtask

  task automatic setAlarm37();
    resetCycle();
    pressMode();
    repeat (3) pressInc();
    pressMode();
    repeat (7) pressInc();
    pressMode();
    checkOutput("setflow_pulse", set_min, 1);
    checkOutput("setflow_a1", alarm_min1, 3);
    checkOutput("setflow_a2", alarm_min2, 7);
    idleCycle();
    checkOutput("setflow_done", {set_min, editing}, 0);
  endtask

  initial begin
    int b, c1, c2;
    bit r, m, i, s, t, sz;

    resetCycle();
    resetCycle();
    idleCycle();

    setAlarm37();

    // Digit wrap from a cleared alarm.
    resetCycle();
    pressMode();
    repeat (6) pressInc();
    checkOutput("wrap_tens", edit_min1, 0);
    pressMode();
    repeat (4) pressInc();
    checkOutput("ones_mid", edit_min2, 4);
    repeat (10) pressInc();
    checkOutput("wrap_ones", edit_min2, 4);
    pressMode();
    idleCycle();

    // Edit timeout with blinking ticks.
    resetCycle();
    pressMode();
    repeat (2) pressInc();
    repeat (TIMEOUT - 1) tickOnly();
    checkOutput("timeout_pre", editing, 1);
    tickOnly();
    checkOutput("timeout_post", editing, 0);
    checkOutput("timeout_alarm", {alarm_min1, alarm_min2}, 0);
    idleCycle();

    // Ring for the full period, then a ring cut short by btn_mode.
    setAlarm37();
    applyStimulus(0, 0, 0, 0, 1, 1, 3, 7);
    checkOutput("ring_rise", ringing, 1);
    repeat (RING_LEN - 1) tickOnly();
    checkOutput("ring_last", ringing, 1);
    tickOnly();
    checkOutput("ring_fall", ringing, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 3, 7);
    tickOnly();
    pressMode();
    checkOutput("ring_stop", {ringing, editing}, 0);
    idleCycle();

    // btn_mode + btn_inc together, and a match while editing.
    pressMode();
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("simul_tens", edit_min1, 3);
    applyStimulus(0, 0, 0, 0, 1, 1, 3, 7);
    checkOutput("edit_no_ring", ringing, 0);

    // Reset mid-edit and mid-ring.
    resetCycle();
    setAlarm37();
    applyStimulus(0, 0, 0, 0, 1, 1, 3, 7);
    repeat (5) tickOnly();
    resetCycle();
    checkOutput("rst_ring", ringing, 0);

    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      b  = $urandom_range(0, 15);
      m  = (b == 0);
      i  = (b == 1) || (b == 2);
      s  = (b == 3);
      t  = ($urandom_range(0, 3) == 0);
      sz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        c1 = mA1; c2 = mA2;
      end else begin
        c1 = $urandom_range(0, 5); c2 = $urandom_range(0, 9);
      end
      applyStimulus(r, m, i, s, t, sz, c1, c2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
